// File: rtl/gpio_int_pkg.sv
// Shared types for the GPIO interrupt acknowledge controller.
package gpio_int_pkg;

  localparam int CODE_W = 7;

  typedef logic [CODE_W-1:0] int_code_t;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    WAIT_REL
  } ack_state_e;

endpackage

// File: rtl/gpio_int_ack_ctrl_if.sv
// INTR/INT_CODE/INTA_N handshake plus the host-side code stream.
// Signal suffixes are from the acknowledge controller's point of view.
interface gpio_int_ack_ctrl_if;
  import gpio_int_pkg::*;

  logic      intr_i;
  int_code_t int_code_i;
  logic      inta_n_o;
  int_code_t code_data_o;
  logic      code_valid_o;
  logic      code_ready_i;

  // Interrupt controller and host side
  modport master (
    output intr_i, int_code_i, code_ready_i,
    input  inta_n_o, code_data_o, code_valid_o
  );

  // Acknowledge controller side
  modport slave (
    input  intr_i, int_code_i, code_ready_i,
    output inta_n_o, code_data_o, code_valid_o
  );

endinterface

// File: rtl/gpio_int_code_fifo.sv
// Single-clock code FIFO. The head is read from registered storage, so a
// push into an empty FIFO becomes visible the cycle after the push.
module gpio_int_code_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 7
) (
  input  logic                     clk_50m,
  input  logic                     rst_50m,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push_ok, pop_ok;

  // A pop on an empty FIFO is dropped; a push is only dropped if full.
  assign pop_ok  = pop_i && (level_q != '0);
  assign push_ok = push_i && (level_q != LVL_FULL);

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok)      level_d = level_q + 1'b1;
    else if (pop_ok && !push_ok) level_d = level_q - 1'b1;
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_50m or posedge rst_50m) begin
    if (rst_50m) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk_50m) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign valid_o = (level_q != '0);
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign level_o = level_q;

endmodule

// File: rtl/gpio_int_ack_ctrl.sv
// Acknowledge side of the GPIO interrupt handshake: synchronises INTR,
// drives the INTA_N pulse, captures the code and queues it for the host.
module gpio_int_ack_ctrl
  import gpio_int_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ACK_CYCLES  = 4,
  parameter int SAMPLE_CYC  = 2,
  parameter int REL_TIMEOUT = 64
) (
  input  logic                         clk_50m,
  input  logic                         rst_50m,
  gpio_int_ack_ctrl_if.slave           bus,
  input  logic                         clr_err_i,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level_o,
  output logic [15:0]                  ack_cnt_o,
  output logic                         timeout_err_o,
  output logic                         busy_o
);

  // state    | meaning
  // IDLE     | waiting for synchronised INTR and free FIFO space
  // ACK      | INTA_N low, counting ACK_CYCLES, code sampled at SAMPLE_CYC
  // WAIT_REL | INTA_N high again, waiting for INTR to drop or timeout

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W = $clog2(ACK_CYCLES);
  localparam int TMR_W = $clog2(REL_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] SAMPLE_IDX = CNT_W'(SAMPLE_CYC);
  localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(ACK_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(REL_TIMEOUT - 1);
  localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(FIFO_DEPTH);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   intr_s;

  ack_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  int_code_t         code_q, code_d;
  logic              inta_n_q, inta_n_d;
  logic [15:0]       ack_cnt_q, ack_cnt_d;
  logic              err_q;

  logic              push;
  int_code_t         push_data;
  logic              set_err;
  logic [LVL_W-1:0]  fifo_level;

  // INTR may be asynchronous to clk_50m
  always_ff @(posedge clk_50m or posedge rst_50m) begin
    if (rst_50m) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], bus.intr_i};
  end

  assign intr_s = sync_q[SYNC_STAGES-1];

  // Handshake sequencing: next state, counters and datapath strobes
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmr_d     = tmr_q;
    code_d    = code_q;
    inta_n_d  = inta_n_q;
    ack_cnt_d = ack_cnt_q;
    push      = 1'b0;
    push_data = code_q;
    set_err   = 1'b0;
    case (state_q)
      IDLE: begin
        // A full FIFO holds off the acknowledge; the controller keeps INTR up.
        if (intr_s && (fifo_level != LVL_FULL)) begin
          state_d  = ACK;
          cnt_d    = '0;
          inta_n_d = 1'b0;
        end
      end
      ACK: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SAMPLE_IDX) code_d = bus.int_code_i;
        if (cnt_q == LAST_IDX) begin
          push      = 1'b1;
          // Sampling on the last ACK cycle must bypass the capture register.
          push_data = (cnt_q == SAMPLE_IDX) ? bus.int_code_i : code_q;
          ack_cnt_d = ack_cnt_q + 16'd1;
          inta_n_d  = 1'b1;
          tmr_d     = '0;
          state_d   = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (!intr_s) begin
          state_d = IDLE;
        end else if (tmr_q == TMR_LAST) begin
          // Treat a stuck-high INTR as a fresh request after flagging it.
          set_err = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and handshake registers; reset releases INTA_N immediately
  always_ff @(posedge clk_50m or posedge rst_50m) begin
    if (rst_50m) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tmr_q     <= '0;
      code_q    <= '0;
      inta_n_q  <= 1'b1;
      ack_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
      code_q    <= code_d;
      inta_n_q  <= inta_n_d;
      ack_cnt_q <= ack_cnt_d;
    end
  end

  // Sticky timeout flag; a new timeout wins over a simultaneous clear
  always_ff @(posedge clk_50m or posedge rst_50m) begin
    if (rst_50m)        err_q <= 1'b0;
    else if (set_err)   err_q <= 1'b1;
    else if (clr_err_i) err_q <= 1'b0;
  end

  gpio_int_code_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CODE_W)
  ) u_fifo (
    .clk_50m     (clk_50m),
    .rst_50m     (rst_50m),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (bus.code_ready_i),
    .data_o      (bus.code_data_o),
    .valid_o     (bus.code_valid_o),
    .level_o     (fifo_level)
  );

  assign bus.inta_n_o  = inta_n_q;
  assign fifo_level_o  = fifo_level;
  assign ack_cnt_o     = ack_cnt_q;
  assign timeout_err_o = err_q;
  assign busy_o        = (state_q != IDLE);

endmodule
